// File: rtl/sd_msb_decoder.sv
`default_nettype none
// ============================================================================
// sd_msb_decoder - recovers a phase-accumulator increment by counting MSB
// rising edges per 2^ACC_WIDTH-cycle window. Option: DECODER_GLITCH_FILTER_EN
// Revision: 1.0
// ============================================================================
module sd_msb_decoder #(
  parameter int ACC_WIDTH   = 24,
  parameter int ADD_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 bit_in,
  output logic [ADD_WIDTH-1:0] value,
  output logic                 valid,
  output logic                 overflow
);

  localparam int CNT_WIDTH = ADD_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH-1:0] WIN_ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ACC_WIDTH-1:0] WIN_LAST = {ACC_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   s_bit;
  logic                   prev_s;
  logic                   rise;
  logic [ACC_WIDTH-1:0]   win_cnt, win_d;
  logic [CNT_WIDTH-1:0]   edge_cnt, edge_d, edge_sum;
  logic [ADD_WIDTH-1:0]   value_d;
  logic                   overflow_d;
  logic                   valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bit_in};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef DECODER_GLITCH_FILTER_EN
  // Majority of three consecutive samples; a lone one-cycle pulse never wins.
  logic [2:0] hist_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '0;
    end else begin
      hist_q <= {hist_q[1:0], sync_out};
    end
  end

  assign s_bit = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
  assign s_bit = sync_out;
`endif

  assign rise = s_bit & ~prev_s;

  // Saturating edge accumulation including this cycle's edge.
  always_comb begin
    edge_sum = edge_cnt;
    if (rise && (edge_cnt != {CNT_WIDTH{1'b1}})) begin
      edge_sum = edge_cnt + CNT_ONE;
    end
  end

  always_comb begin
    state_d    = state_q;
    win_d      = '0;
    edge_d     = '0;
    value_d    = value;
    overflow_d = overflow;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = ARM;
        end
      end
      ARM: begin
        // prev_s is refreshed this cycle; no edge is counted.
        state_d = enable ? MEASURE : IDLE;
      end
      MEASURE: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (win_cnt == WIN_LAST) begin
          valid_d = 1'b1;
          if (edge_sum[ADD_WIDTH]) begin
            value_d    = {ADD_WIDTH{1'b1}};
            overflow_d = 1'b1;
          end else begin
            value_d    = edge_sum[ADD_WIDTH-1:0];
            overflow_d = 1'b0;
          end
        end else begin
          win_d  = win_cnt + WIN_ONE;
          edge_d = edge_sum;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_cnt  <= '0;
      edge_cnt <= '0;
      prev_s   <= 1'b0;
      value    <= '0;
      overflow <= 1'b0;
      valid    <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_cnt  <= win_d;
      edge_cnt <= edge_d;
      prev_s   <= s_bit;
      value    <= value_d;
      overflow <= overflow_d;
      valid    <= valid_d;
    end
  end

endmodule
`default_nettype wire
